// File: rtl/uart_bus_bridge_pkg.sv
// Shared constants, state encoding and helpers for the serial-to-bus bridge.
// Command and reply bytes are the host-visible protocol alphabet.
package uart_bus_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;

  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    BUS,
    SEND
  } state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/uart_byte_phy.sv
// 8N1 byte-level serial engines: one receiver, one transmitter.
// Bit period is CLK_DIV+1 clocks, fixed at elaboration.
module uart_byte_phy #(
  parameter logic [15:0] CLK_DIV = 16'd103
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_load,
  output logic       o_tx_busy,
  output logic       o_tx
);

  localparam logic [15:0] HALF = CLK_DIV >> 1;

  logic        r_rx_prev;
  logic        r_rx_busy;
  logic [15:0] r_rx_cnt;
  logic [3:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;

  logic [9:0]  r_tx_shift;
  logic        r_tx_busy;
  logic [15:0] r_tx_cnt;
  logic [3:0]  r_tx_bits;

  // r_rx_bit: 0 = start, 1..8 = data, 9 = stop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_prev  <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_prev  <= i_rx;
      r_rx_valid <= 1'b0;
      if (!r_rx_busy) begin
        if (r_rx_prev && !i_rx) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= HALF;
          r_rx_bit  <= '0;
        end
      end else if (r_rx_cnt != 16'd0) begin
        r_rx_cnt <= r_rx_cnt - 16'd1;
      end else begin
        r_rx_cnt <= CLK_DIV;
        r_rx_bit <= r_rx_bit + 4'd1;
        unique case (1'b1)
          (r_rx_bit == 4'd0): begin
            if (i_rx) r_rx_busy <= 1'b0;
          end
          (r_rx_bit == 4'd9): begin
            r_rx_busy <= 1'b0;
            if (i_rx) begin
              r_rx_data  <= r_rx_shift;
              r_rx_valid <= 1'b1;
            end
          end
          default: r_rx_shift <= {i_rx, r_rx_shift[7:1]};
        endcase
      end
    end
  end

  // Shift register idles all-ones so its LSB is the line level
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_shift <= '1;
      r_tx_busy  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bits  <= '0;
    end else if (i_tx_load && !r_tx_busy) begin
      r_tx_shift <= {1'b1, i_tx_data, 1'b0};
      r_tx_busy  <= 1'b1;
      r_tx_cnt   <= CLK_DIV;
      r_tx_bits  <= 4'd9;
    end else if (r_tx_busy) begin
      if (r_tx_cnt != 16'd0) begin
        r_tx_cnt <= r_tx_cnt - 16'd1;
      end else if (r_tx_bits == 4'd0) begin
        r_tx_busy <= 1'b0;
      end else begin
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        r_tx_bits  <= r_tx_bits - 4'd1;
        r_tx_cnt   <= CLK_DIV;
      end
    end
  end

  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_tx_busy  = r_tx_busy;
  assign o_tx       = r_tx_shift[0];

endmodule

// File: rtl/uart_bus_bridge.sv
// Serial debug bridge: host command frames become 32-bit bus reads/writes.
// Replies go back over the same 8N1 link.
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter logic [15:0] CLK_DIV = 16'd103
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_in,
  output logic        tx_out,
  output logic [31:0] address_out,
  output logic        sel_out,
  output logic        read_out,
  input  logic [31:0] read_value_in,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic        ready_in
);

  logic       w_rx_valid;
  logic [7:0] w_rx_data;
  logic       w_tx_busy;
  logic       w_tx_load;
  logic [7:0] w_tx_data;
  logic       w_cmd_ok;

  state_t r_state;
  state_t w_next;

  logic [1:0]  r_idx;
  logic        r_is_write;
  logic        r_sel;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_reply;
  logic [1:0]  r_rem;

  uart_byte_phy #(.CLK_DIV(CLK_DIV)) u_phy (
    .clk       (clk),
    .reset     (reset),
    .i_rx      (rx_in),
    .o_rx_data (w_rx_data),
    .o_rx_valid(w_rx_valid),
    .i_tx_data (w_tx_data),
    .i_tx_load (w_tx_load),
    .o_tx_busy (w_tx_busy),
    .o_tx      (tx_out)
  );

  assign w_cmd_ok = is_cmd(w_rx_data);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_tx_load = 1'b0;
    w_tx_data = r_reply[7:0];
    unique case (r_state)
      IDLE: begin
        if (w_rx_valid) w_next = w_cmd_ok ? GET_ADDR : SEND;
      end
      GET_ADDR: begin
        if (w_rx_valid && r_idx == 2'd3)
          w_next = r_is_write ? GET_DATA : BUS;
      end
      GET_DATA: begin
        if (w_rx_valid && r_idx == 2'd3) w_next = BUS;
      end
      BUS: begin
        if (ready_in) w_next = SEND;
      end
      SEND: begin
        if (!w_tx_busy) begin
          w_tx_load = 1'b1;
          if (r_rem == 2'd0) w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Bytes arrive LSB first, so each one enters at the top and shifts down
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= '0;
      r_is_write <= 1'b0;
      r_sel      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_reply    <= '0;
      r_rem      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_rx_valid) begin
            r_is_write <= (w_rx_data == CMD_WRITE);
            r_idx      <= '0;
            r_reply    <= {24'd0, RSP_ERR};
            r_rem      <= '0;
          end
        end
        GET_ADDR: begin
          if (w_rx_valid) begin
            r_addr <= {w_rx_data, r_addr[31:8]};
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3 && !r_is_write) r_sel <= 1'b1;
          end
        end
        GET_DATA: begin
          if (w_rx_valid) begin
            r_wdata <= {w_rx_data, r_wdata[31:8]};
            r_idx   <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_sel <= 1'b1;
          end
        end
        BUS: begin
          if (ready_in) begin
            r_sel <= 1'b0;
            if (r_is_write) begin
              r_reply <= {24'd0, RSP_OK};
              r_rem   <= 2'd0;
            end else begin
              r_reply <= read_value_in;
              r_rem   <= 2'd3;
            end
          end
        end
        SEND: begin
          if (!w_tx_busy) begin
            r_reply <= {8'd0, r_reply[31:8]};
            r_rem   <= r_rem - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sel_out         = r_sel;
  assign read_out        = r_sel & ~r_is_write;
  assign write_mask_out  = (r_sel && r_is_write) ? 4'hF : 4'h0;
  assign address_out     = r_addr & ADDR_MASK;
  assign write_value_out = r_wdata;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge at 4 clocks per serial bit.
// Serial host, bus responder and reply decoder are modelled here.
module tb_uart_bus_bridge;
  import uart_bus_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_in = 1'b1;
  logic        tx_out;
  logic [31:0] address_out;
  logic        sel_out;
  logic        read_out;
  logic [31:0] rdata = '0;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic        ready_in = 1'b0;

  always #5 clk = ~clk;

  uart_bus_bridge #(.CLK_DIV(16'd3)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_in          (rx_in),
    .tx_out         (tx_out),
    .address_out    (address_out),
    .sel_out        (sel_out),
    .read_out       (read_out),
    .read_value_in  (rdata),
    .write_mask_out (write_mask_out),
    .write_value_out(write_value_out),
    .ready_in       (ready_in)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Bus responder with programmable ready latency
  int          lat = 0;
  int          rcnt = 0;
  int          unstable = 0;
  logic [31:0] a_first;
  logic [31:0] bq_addr[$];
  logic [31:0] bq_wd[$];
  logic [3:0]  bq_mask[$];
  logic        bq_rd[$];
  int          bq_sel[$];

  always @(negedge clk) begin
    if (sel_out) begin
      if (rcnt == 0) a_first = address_out;
      else if (address_out !== a_first) unstable++;
      if (rcnt == lat) begin
        ready_in = 1'b1;
        bq_addr.push_back(address_out);
        bq_wd.push_back(write_value_out);
        bq_mask.push_back(write_mask_out);
        bq_rd.push_back(read_out);
        bq_sel.push_back(rcnt + 1);
      end else begin
        ready_in = 1'b0;
      end
      rcnt++;
    end else begin
      ready_in = 1'b0;
      rcnt = 0;
    end
  end

  // Reply decoder: samples mid-bit
  logic [7:0] rq[$];
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_out === 1'b0) begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = tx_out;
        end
        repeat (4) @(negedge clk);
        rq.push_back(b);
      end
    end
  end

  int rxv = 0;
  always @(negedge clk) if (dut.w_rx_valid) rxv++;

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      rx_in = f[i];
      repeat (4) @(posedge clk);
      #1;
    end
    rx_in = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_rsp(input int n, input string nm);
    int t;
    t = 0;
    while (rq.size() < n && t < 4000) begin
      @(posedge clk);
      t++;
    end
    chk({nm, "_reply_timeout"}, 32'(rq.size() >= n), 32'd1);
    repeat (10) @(posedge clk);
  endtask

  task automatic clear_q();
    rq.delete();
    bq_addr.delete();
    bq_wd.delete();
    bq_mask.delete();
    bq_rd.delete();
    bq_sel.delete();
    unstable = 0;
  endtask

  task automatic chk_bus(input string nm, input logic [31:0] addr,
                         input logic rd, input logic [31:0] wd,
                         input int sel);
    chk({nm, "_bus_count"}, 32'(bq_addr.size()), 32'd1);
    if (bq_addr.size() > 0) begin
      chk({nm, "_addr"}, bq_addr[0], addr);
      chk({nm, "_read"}, 32'(bq_rd[0]), 32'(rd));
      chk({nm, "_mask"}, 32'(bq_mask[0]), rd ? 32'h0 : 32'hF);
      chk({nm, "_sel_cycles"}, 32'(bq_sel[0]), 32'(sel));
      if (!rd) chk({nm, "_wdata"}, bq_wd[0], wd);
    end
    chk({nm, "_stable"}, 32'(unstable), 32'd0);
  endtask

  task automatic chk_rsp(input string nm, input logic [31:0] exp,
                         input int n);
    chk({nm, "_reply_len"}, 32'(rq.size()), 32'(n));
    for (int k = 0; k < n; k++)
      if (k < rq.size())
        chk($sformatf("%s_reply%0d", nm, k), 32'(rq[k]), 32'(exp[8*k +: 8]));
  endtask

  typedef struct {
    string       nm;
    logic [71:0] bytes;
    int          n;
    int          lat;
    logic [31:0] rdata;
    logic        bus;
    logic [31:0] addr;
    logic        rd;
    logic [31:0] wd;
    int          sel;
    logic [31:0] rsp;
    int          nrsp;
  } vec_t;

  vec_t v[5];

  initial begin
    int t;
    int rxv0;

    v[0] = '{"write", 72'hDE_AD_BE_EF_00_00_00_10_57, 9, 2, 32'h0,
             1'b1, 32'h10, 1'b0, 32'hDEADBEEF, 3, 32'h4B, 1};
    v[1] = '{"read", 72'h00_00_00_00_13_52, 5, 0, 32'h12345678,
             1'b1, 32'h10, 1'b1, 32'h0, 1, 32'h12345678, 4};
    v[2] = '{"badcmd", 72'h41, 1, 0, 32'h0,
             1'b0, 32'h0, 1'b0, 32'h0, 0, 32'h3F, 1};
    v[3] = '{"read2", 72'h00_00_01_04_52, 5, 1, 32'hCAFEF00D,
             1'b1, 32'h104, 1'b1, 32'h0, 2, 32'hCAFEF00D, 4};
    v[4] = '{"write2", 72'h00_00_00_01_FF_FF_FF_FF_57, 9, 0, 32'h0,
             1'b1, 32'hFFFFFFFC, 1'b0, 32'h1, 1, 32'h4B, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx_out), 32'd1);
    chk("rst_sel", 32'(sel_out), 32'd0);
    chk("rst_read", 32'(read_out), 32'd0);
    chk("rst_mask", 32'(write_mask_out), 32'd0);
    chk("rst_addr", address_out, 32'd0);
    chk("rst_wdata", write_value_out, 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      clear_q();
      lat = v[i].lat;
      rdata = v[i].rdata;
      for (int b = 0; b < v[i].n; b++) send_byte(v[i].bytes[8*b +: 8], 1'b1);
      wait_rsp(v[i].nrsp, v[i].nm);
      if (v[i].bus)
        chk_bus(v[i].nm, v[i].addr, v[i].rd, v[i].wd, v[i].sel);
      else
        chk({v[i].nm, "_no_bus"}, 32'(bq_addr.size()), 32'd0);
      chk_rsp(v[i].nm, v[i].rsp, v[i].nrsp);
    end

    // Framing error on third address byte shifts later bytes down
    clear_q();
    lat = 1;
    send_byte(8'h57, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'h40, 1'b0);
    send_byte(8'h50, 1'b1);
    send_byte(8'h60, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    wait_rsp(1, "frame");
    chk_bus("frame", 32'h60503020, 1'b0, 32'h44332211, 2);
    chk_rsp("frame", 32'h4B, 1);

    // One-cycle low glitch on idle line
    clear_q();
    rxv0 = rxv;
    @(posedge clk);
    #1 rx_in = 1'b0;
    @(posedge clk);
    #1 rx_in = 1'b1;
    repeat (60) @(posedge clk);
    chk("glitch_rxv", 32'(rxv - rxv0), 32'd0);
    chk("glitch_state", 32'(dut.r_state), 32'(IDLE));
    chk("glitch_reply", 32'(rq.size()), 32'd0);
    chk("glitch_bus", 32'(bq_addr.size()), 32'd0);

    // Reset while the responder stalls
    clear_q();
    lat = 1000000;
    send_byte(8'h52, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    t = 0;
    while (!sel_out && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("rstbus_reached", 32'(sel_out), 32'd1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rstbus_sel", 32'(sel_out), 32'd0);
    chk("rstbus_tx", 32'(tx_out), 32'd1);
    chk("rstbus_read", 32'(read_out), 32'd0);
    chk("rstbus_state", 32'(dut.r_state), 32'(IDLE));
    repeat (100) @(posedge clk);
    chk("rstbus_no_reply", 32'(rq.size()), 32'd0);
    chk("rstbus_no_bus", 32'(bq_addr.size()), 32'd0);

    clear_q();
    lat = 0;
    rdata = 32'hA5A50F0F;
    send_byte(8'h52, 1'b1);
    send_byte(8'h24, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_rsp(4, "after_rst");
    chk_bus("after_rst", 32'h24, 1'b1, 32'h0, 1);
    chk_rsp("after_rst", 32'hA5A50F0F, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
